// File: rtl/ahb_lite_dmem_mux.sv
// AHB-Lite 1-master/2-slave dmem interconnect: address decode, data-phase response mux,
// a default slave answering unmapped transfers with a two-cycle ERROR, and a fault record.
module ahb_lite_dmem_mux #(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S0_MASK  = 32'hFFFF_FF00,
  parameter logic [31:0] S1_BASE  = 32'h0000_0100,
  parameter logic [31:0] S1_MASK  = 32'hFFFF_FF00,
  parameter int          ERRCNT_W = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  output logic [31:0]         HRDATA,
  output logic                HREADY,
  output logic                HRESP,
  output logic                HSEL_S0,
  output logic                HSEL_S1,
  input  logic [31:0]         HRDATA_S0,
  input  logic [31:0]         HRDATA_S1,
  input  logic                HREADYOUT_S0,
  input  logic                HREADYOUT_S1,
  input  logic                HRESP_S0,
  input  logic                HRESP_S1,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [31:0]         err_addr,
  output logic                err_write
);

  typedef enum logic [1:0] {DSEL_NONE, DSEL_S0, DSEL_S1, DSEL_DEF} dsel_t;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  localparam logic [1:0][31:0] SLV_BASE = {S1_BASE, S0_BASE};
  localparam logic [1:0][31:0] SLV_MASK = {S1_MASK, S0_MASK};

  logic [1:0]          hit;
  logic                trans_active;
  logic                load_def;
  dsel_t               dsel_reg, dsel_next;
  ds_state_t           ds_state_reg;
  logic [ERRCNT_W-1:0] err_cnt_reg;
  logic [31:0]         err_addr_reg;
  logic                err_write_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_decode
      assign hit[gi] = (HADDR & SLV_MASK[gi]) == SLV_BASE[gi];
    end
  endgenerate

  // Slave 0 wins when the two windows overlap.
  assign HSEL_S0 = hit[0];
  assign HSEL_S1 = hit[1] & ~hit[0];

  assign trans_active = HTRANS inside {2'b10, 2'b11};

  always_comb begin
    dsel_next = DSEL_NONE;
    if (trans_active) begin
      if (hit[0])      dsel_next = DSEL_S0;
      else if (hit[1]) dsel_next = DSEL_S1;
      else             dsel_next = DSEL_DEF;
    end
  end

  assign load_def = HREADY && (dsel_next == DSEL_DEF);

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    case (dsel_reg)
      DSEL_S0: begin
        HREADY = HREADYOUT_S0;
        HRESP  = HRESP_S0;
        HRDATA = HRDATA_S0;
      end
      DSEL_S1: begin
        HREADY = HREADYOUT_S1;
        HRESP  = HRESP_S1;
        HRDATA = HRDATA_S1;
      end
      DSEL_DEF: begin
        HREADY = (ds_state_reg == DS_ERR2);
        HRESP  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_reg      <= DSEL_NONE;
      ds_state_reg  <= DS_IDLE;
      err_cnt_reg   <= '0;
      err_addr_reg  <= 32'h0;
      err_write_reg <= 1'b0;
    end else begin
      if (HREADY) begin
        // ERR2 exits here as well: either re-arm for another unmapped access or go idle.
        dsel_reg     <= dsel_next;
        ds_state_reg <= load_def ? DS_ERR1 : DS_IDLE;
        if (load_def) begin
          err_addr_reg  <= HADDR;
          err_write_reg <= HWRITE;
          if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + ERRCNT_W'(1);
        end
      end else if (ds_state_reg == DS_ERR1) begin
        ds_state_reg <= DS_ERR2;
      end
    end
  end

  assign err_cnt   = err_cnt_reg;
  assign err_addr  = err_addr_reg;
  assign err_write = err_write_reg;

endmodule

// File: tb/tb_ahb_lite_dmem_mux.sv
// Directed bench for ahb_lite_dmem_mux: inputs change 1 ns after HCLK rise, outputs checked mid-cycle.
module tb_ahb_lite_dmem_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP, HSEL_S0, HSEL_S1;
  logic [31:0] HRDATA_S0, HRDATA_S1;
  logic        HREADYOUT_S0, HREADYOUT_S1, HRESP_S0, HRESP_S1;
  logic [7:0]  err_cnt;
  logic [31:0] err_addr;
  logic        err_write;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_dmem_mux dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HSEL_S0(HSEL_S0), .HSEL_S1(HSEL_S1),
    .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1),
    .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1),
    .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1),
    .err_cnt(err_cnt), .err_addr(err_addr), .err_write(err_write)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HRDATA_S0 = 32'h0; HRDATA_S1 = 32'h0;
    HREADYOUT_S0 = 1'b1; HREADYOUT_S1 = 1'b1; HRESP_S0 = 1'b0; HRESP_S1 = 1'b0;

    // Reset state
    step(); step(); settle();
    chk("rst_hready", 32'(HREADY), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_write", 32'(err_write), 32'h0);
    step(); HRESET = 1'b0; settle();

    // Read 0x14 from S0
    step(); HADDR = 32'h14; HTRANS = 2'b10; HWRITE = 1'b0; settle();
    $display("txn: read 0x14 address phase");
    chk("rd14_hsel_s0", 32'(HSEL_S0), 32'h1);
    chk("rd14_hsel_s1", 32'(HSEL_S1), 32'h0);
    step(); HTRANS = 2'b00; HRDATA_S0 = 32'h60; HREADYOUT_S0 = 1'b1; settle();
    chk("rd14_hrdata", HRDATA, 32'h60);
    chk("rd14_hready", 32'(HREADY), 32'h1);
    chk("rd14_hresp", 32'(HRESP), 32'h0);

    // Write 0x104 to S1 with 3 wait states
    step(); HADDR = 32'h104; HTRANS = 2'b10; HWRITE = 1'b1; settle();
    $display("txn: write 0x104 address phase");
    chk("wr104_hsel_s1", 32'(HSEL_S1), 32'h1);
    chk("wr104_hsel_s0", 32'(HSEL_S0), 32'h0);
    step(); HTRANS = 2'b00; HWRITE = 1'b0; HREADYOUT_S1 = 1'b0; settle();
    chk("wr104_wait1", 32'(HREADY), 32'h0);
    chk("wr104_wait1_s0", 32'(HSEL_S0), 32'h0);
    step(); settle();
    chk("wr104_wait2", 32'(HREADY), 32'h0);
    step(); settle();
    chk("wr104_wait3", 32'(HREADY), 32'h0);
    chk("wr104_wait3_s0", 32'(HSEL_S0), 32'h0);
    step(); HREADYOUT_S1 = 1'b1; settle();
    chk("wr104_done", 32'(HREADY), 32'h1);
    chk("wr104_resp", 32'(HRESP), 32'h0);

    // Slave ERROR passes through and is not counted
    step(); HADDR = 32'h108; HTRANS = 2'b10; settle();
    step(); HTRANS = 2'b00; HRESP_S1 = 1'b1; HRDATA_S1 = 32'h5A5A; settle();
    $display("txn: read 0x108 with slave error");
    chk("s1err_hresp", 32'(HRESP), 32'h1);
    chk("s1err_hrdata", HRDATA, 32'h5A5A);
    chk("s1err_cnt", 32'(err_cnt), 32'h0);
    step(); HRESP_S1 = 1'b0; settle();
    chk("s1err_after_resp", 32'(HRESP), 32'h0);
    chk("s1err_after_rdata", HRDATA, 32'h0);

    // Unmapped read 0x8000_0000
    step(); HADDR = 32'h8000_0000; HTRANS = 2'b10; HWRITE = 1'b0; settle();
    $display("txn: unmapped read 0x80000000");
    chk("um_hsel_s0", 32'(HSEL_S0), 32'h0);
    chk("um_hsel_s1", 32'(HSEL_S1), 32'h0);
    step(); HTRANS = 2'b00; settle();
    chk("um_c1_hready", 32'(HREADY), 32'h0);
    chk("um_c1_hresp", 32'(HRESP), 32'h1);
    chk("um_c1_hrdata", HRDATA, 32'h0);
    chk("um_err_cnt", 32'(err_cnt), 32'h1);
    chk("um_err_addr", err_addr, 32'h8000_0000);
    chk("um_err_write", 32'(err_write), 32'h0);
    step(); settle();
    chk("um_c2_hready", 32'(HREADY), 32'h1);
    chk("um_c2_hresp", 32'(HRESP), 32'h1);
    step(); settle();
    chk("um_after_hready", 32'(HREADY), 32'h1);
    chk("um_after_hresp", 32'(HRESP), 32'h0);

    // Reset, then back-to-back unmapped followed by mapped read of 0x0
    step(); HRESET = 1'b1; settle();
    step(); HRESET = 1'b0; settle();
    chk("rst2_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst2_err_addr", err_addr, 32'h0);
    step(); HADDR = 32'h9000_0000; HTRANS = 2'b10; HWRITE = 1'b1; settle();
    $display("txn: unmapped write 0x90000000");
    step(); HADDR = 32'hA000_0000; HWRITE = 1'b0; settle();
    chk("b2b_a_c1_hready", 32'(HREADY), 32'h0);
    chk("b2b_a_c1_hresp", 32'(HRESP), 32'h1);
    chk("b2b_a_err_write", 32'(err_write), 32'h1);
    chk("b2b_a_err_addr", err_addr, 32'h9000_0000);
    step(); settle();
    $display("txn: unmapped read 0xA0000000");
    chk("b2b_a_c2_hready", 32'(HREADY), 32'h1);
    chk("b2b_a_c2_hresp", 32'(HRESP), 32'h1);
    chk("b2b_a_c2_cnt", 32'(err_cnt), 32'h1);
    step(); HADDR = 32'h0; settle();
    chk("b2b_b_c1_hready", 32'(HREADY), 32'h0);
    chk("b2b_b_c1_hresp", 32'(HRESP), 32'h1);
    chk("b2b_b_err_addr", err_addr, 32'hA000_0000);
    chk("b2b_b_err_write", 32'(err_write), 32'h0);
    step(); settle();
    chk("b2b_b_c2_hready", 32'(HREADY), 32'h1);
    chk("b2b_b_c2_hresp", 32'(HRESP), 32'h1);
    step(); HTRANS = 2'b00; HRDATA_S0 = 32'hCAFE; HREADYOUT_S0 = 1'b1; settle();
    $display("txn: read 0x0 after errors");
    chk("b2b_s0_hrdata", HRDATA, 32'hCAFE);
    chk("b2b_s0_hready", 32'(HREADY), 32'h1);
    chk("b2b_s0_hresp", 32'(HRESP), 32'h0);
    chk("b2b_err_cnt", 32'(err_cnt), 32'h2);

    // 300 unmapped accesses: counter saturates
    step(); HADDR = 32'h8000_0000; HTRANS = 2'b10; settle();
    for (int i = 1; i <= 300; i++) begin
      step(); step(); settle();
      if (i == 100) chk("sat_cnt_100", 32'(err_cnt), 32'd102);
      if (i == 252) chk("sat_cnt_252", 32'(err_cnt), 32'd254);
      if (i == 253) chk("sat_cnt_253", 32'(err_cnt), 32'd255);
    end
    $display("txn: 300 unmapped accesses done");
    chk("sat_cnt_300", 32'(err_cnt), 32'hFF);
    chk("sat_err2_hready", 32'(HREADY), 32'h1);
    HTRANS = 2'b00;
    step(); settle();
    chk("sat_idle_hresp", 32'(HRESP), 32'h0);

    // Reset asserted in DS_ERR1
    step(); HADDR = 32'hC000_0000; HTRANS = 2'b10; settle();
    step(); HTRANS = 2'b00; HRESET = 1'b1; settle();
    $display("txn: reset during ERR1");
    chk("rerr_pre_hready", 32'(HREADY), 32'h0);
    step(); HRESET = 1'b0; settle();
    chk("rerr_hready", 32'(HREADY), 32'h1);
    chk("rerr_hresp", 32'(HRESP), 32'h0);
    chk("rerr_err_cnt", 32'(err_cnt), 32'h0);
    step(); HADDR = 32'h14; HTRANS = 2'b10; settle();
    step(); HTRANS = 2'b00; HRDATA_S0 = 32'h60; settle();
    $display("txn: read 0x14 after reset");
    chk("rerr_rd_hrdata", HRDATA, 32'h60);
    chk("rerr_rd_hready", 32'(HREADY), 32'h1);
    chk("rerr_rd_hresp", 32'(HRESP), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
